// File: rtl/audio_capture_pkg.sv
// Shared constants and state encoding for the line-in capture path.
`timescale 1ns/1ps
package audio_capture_pkg;

   // One buffer half is one SD block: 2^9 = 512 bytes.
   localparam int BUFFER_ADDR_BITS_DEF = 9;

   // PCM word width delivered by the codec ADC.
   localparam int SAMPLE_BITS  = 16;
   localparam int BIT_CNT_BITS = $clog2(SAMPLE_BITS);
   localparam logic [BIT_CNT_BITS-1:0] LAST_BIT = BIT_CNT_BITS'(SAMPLE_BITS - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ALIGN,
      ST_SKIP,
      ST_SHIFT,
      ST_WR_LO,
      ST_WR_HI
   } cap_state_e;

endpackage

// File: rtl/audio_capture_i2s_sync.sv
// Brings BCLK, ADCLRCK and ADCDAT into the clk domain with equal delay and
// produces registered BCLK-rise and LRCK-rise/fall pulses plus a data copy
// aligned with those pulses.
`timescale 1ns/1ps
module audio_capture_i2s_sync (
   input  logic clk,
   input  logic rst,
   input  logic bclk_i,
   input  logic lrck_i,
   input  logic dat_i,
   output logic bclk_rise_o,
   output logic lrck_rise_o,
   output logic lrck_fall_o,
   output logic dat_o
);

   localparam int NUM_CH = 3;

   logic [NUM_CH-1:0] pin_w;
   logic [NUM_CH-1:0] sync_w;
   logic [1:0]        prev_q;
   logic              bclk_rise_q;
   logic              lrck_rise_q;
   logic              lrck_fall_q;
   logic              dat_q;

   // Channel order: 0 = BCLK, 1 = LRCK, 2 = DATA.
   assign pin_w = {dat_i, lrck_i, bclk_i};

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_sync
         logic meta_q;
         logic sync_q;

         // Two-flop synchronizer for one codec line.
         always_ff @(posedge clk) begin
            if (rst) begin
               meta_q <= 1'b0;
               sync_q <= 1'b0;
            end else begin
               meta_q <= pin_w[gi];
               sync_q <= meta_q;
            end
         end

         assign sync_w[gi] = sync_q;
      end
   endgenerate

   // Edge register: pulses and data land in the same cycle, so the FSM can
   // sample DATA exactly when it sees the BCLK rise.
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q      <= 2'b00;
         bclk_rise_q <= 1'b0;
         lrck_rise_q <= 1'b0;
         lrck_fall_q <= 1'b0;
         dat_q       <= 1'b0;
      end else begin
         prev_q      <= sync_w[1:0];
         bclk_rise_q <= sync_w[0] & ~prev_q[0];
         lrck_rise_q <= sync_w[1] & ~prev_q[1];
         lrck_fall_q <= ~sync_w[1] & prev_q[1];
         dat_q       <= sync_w[2];
      end
   end

   assign bclk_rise_o = bclk_rise_q;
   assign lrck_rise_o = lrck_rise_q;
   assign lrck_fall_o = lrck_fall_q;
   assign dat_o       = dat_q;

endmodule

// File: rtl/audio_capture.sv
// Line-in capture: deserializes 16-bit I2S ADC words and writes them as
// little-endian PCM bytes into the active half of a double buffer, handing
// each completed half to the consumer through a filled/drained handshake.
`timescale 1ns/1ps
module audio_capture
   import audio_capture_pkg::*;
#(
   parameter int BUFFER_ADDR_BITS = BUFFER_ADDR_BITS_DEF
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        enable_i,
   input  logic                        stereo_i,
   input  logic                        codec_bclk_i,
   input  logic                        codec_adclrck_i,
   input  logic                        codec_adcdat_i,
   output logic [BUFFER_ADDR_BITS-1:0] buffer_addr_o,
   output logic                        buffer_sel_o,
   output logic                        buffer_wren_o,
   output logic [7:0]                  buffer_data_o,
   output logic                        buffer_filled_o,
   input  logic                        buffer_drained_i,
   output logic                        overrun_o
);

   localparam logic [BUFFER_ADDR_BITS-1:0] ADDR_LAST = '1;

   logic bclk_rise_w;
   logic lrck_rise_w;
   logic lrck_fall_w;
   logic dat_w;
   logic wren_w;

   cap_state_e                  state_q,   state_d;
   logic                        stereo_q,  stereo_d;
   logic                        any_edge_q, any_edge_d;   // next word may start on either LRCK edge
   logic [BIT_CNT_BITS-1:0]     cnt_q,     cnt_d;
   logic [SAMPLE_BITS-1:0]      shift_q,   shift_d;
   logic [BUFFER_ADDR_BITS-1:0] addr_q,    addr_d;
   logic                        sel_q,     sel_d;
   logic                        filled_q,  filled_d;
   logic                        overrun_q, overrun_d;

   audio_capture_i2s_sync u_sync (
      .clk         (clk),
      .rst         (rst),
      .bclk_i      (codec_bclk_i),
      .lrck_i      (codec_adclrck_i),
      .dat_i       (codec_adcdat_i),
      .bclk_rise_o (bclk_rise_w),
      .lrck_rise_o (lrck_rise_w),
      .lrck_fall_o (lrck_fall_w),
      .dat_o       (dat_w)
   );

   // State and datapath registers; reset discards any partial sample.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         stereo_q   <= 1'b0;
         any_edge_q <= 1'b0;
         cnt_q      <= '0;
         shift_q    <= '0;
         addr_q     <= '0;
         sel_q      <= 1'b0;
         filled_q   <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         stereo_q   <= stereo_d;
         any_edge_q <= any_edge_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         addr_q     <= addr_d;
         sel_q      <= sel_d;
         filled_q   <= filled_d;
         overrun_q  <= overrun_d;
      end
   end

   // Next-state logic: word alignment, bit shifting, byte writes and the
   // half-buffer handover.
   always_comb begin
      state_d    = state_q;
      stereo_d   = stereo_q;
      any_edge_d = any_edge_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      addr_d     = addr_q;
      sel_d      = sel_q;
      filled_d   = filled_q;
      overrun_d  = overrun_q;
      wren_w     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (enable_i) begin
               stereo_d   = stereo_i;
               any_edge_d = 1'b0;          // always restart on a left word
               state_d    = ST_ALIGN;
            end
         end
         ST_ALIGN: begin
            if (!enable_i) begin
               state_d = ST_IDLE;
            end else if (lrck_fall_w || (any_edge_q && lrck_rise_w)) begin
               state_d = ST_SKIP;
            end
         end
         ST_SKIP: begin
            // The first BCLK after the LRCK edge carries no data in I2S.
            if (!enable_i) begin
               state_d = ST_IDLE;
            end else if (bclk_rise_w) begin
               cnt_d   = '0;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            // A started word always completes, even if enable drops.
            if (bclk_rise_w) begin
               shift_d = {shift_q[SAMPLE_BITS-2:0], dat_w};
               cnt_d   = cnt_q + 1'b1;
               if (cnt_q == LAST_BIT) begin
                  state_d = ST_WR_LO;
               end
            end
         end
         ST_WR_LO: begin
            wren_w  = 1'b1;
            state_d = ST_WR_HI;
         end
         ST_WR_HI: begin
            wren_w = 1'b1;
            if (!enable_i) begin
               state_d = ST_IDLE;
            end else begin
               any_edge_d = stereo_q;      // mono skips the right word
               state_d    = ST_ALIGN;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (wren_w) begin
         addr_d = addr_q + 1'b1;           // wraps to 0 after the last byte
      end

      if (wren_w && (addr_q == ADDR_LAST)) begin
         if (!filled_q || buffer_drained_i) begin
            sel_d    = ~sel_q;
            filled_d = 1'b1;
         end else begin
            overrun_d = 1'b1;              // consumer late: keep writing this half
         end
      end else if (buffer_drained_i) begin
         filled_d = 1'b0;
      end
   end

   assign buffer_addr_o   = addr_q;
   assign buffer_sel_o    = sel_q;
   assign buffer_wren_o   = wren_w;
   assign buffer_data_o   = !wren_w ? 8'h00 :
                            (state_q == ST_WR_HI) ? shift_q[SAMPLE_BITS-1:8] : shift_q[7:0];
   assign buffer_filled_o = filled_q;
   assign overrun_o       = overrun_q;

endmodule
